// File: rtl/reflex_pkg.sv
// ---------------------------------------------------------------------------
// reflex_pkg
//
// Shared definitions for the reflex trial controller:
//   - state_e        : trial FSM states, 3-bit encoding
//   - CLK_PER_MS_DEF : default clocks per millisecond (100 MHz board clock)
//   - MAX_MS_DEF     : default saturation limit of the reaction count
//   - RESULT_W       : width of the reaction-time result (fits 0..9999)
// ---------------------------------------------------------------------------
package reflex_pkg;

    localparam int CLK_PER_MS_DEF = 100_000;
    localparam int MAX_MS_DEF     = 9999;
    localparam int RESULT_W       = 14;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_GO    = 3'd2,
        S_DONE  = 3'd3,
        S_EARLY = 3'd4
    } state_e;

endpackage : reflex_pkg

// File: rtl/ms_tick.sv
// ---------------------------------------------------------------------------
// ms_tick
//
// Millisecond prescaler. Counts enabled cycles 0..CLK_PER_MS-1 and emits a
// one-cycle tick on the last count, so a tick appears once every CLK_PER_MS
// enabled cycles. Dropping en returns the count to 0, so every enable window
// starts a fresh millisecond.
//
// Ports:
//   ck    in  1 : clock, rising edge
//   reset in  1 : asynchronous, active-high
//   en    in  1 : count enable; low forces the count back to 0
//   tick  out 1 : one-cycle pulse at the end of each millisecond
// ---------------------------------------------------------------------------
module ms_tick
    import reflex_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
    input  logic ck,
    input  logic reset,
    input  logic en,
    output logic tick
);

    // A one-cycle millisecond still needs a 1-bit counter to stay legal.
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the registered count: the tick is the last cycle of the
    // millisecond, and the consumer acts on it at the following edge.
    assign tick = en && (cnt_q == LAST);

endmodule : ms_tick

// File: rtl/reflex_ctrl.sv
// ---------------------------------------------------------------------------
// reflex_ctrl
//
// Trial controller for the reflex-measurement design. Releases the external
// 5 s delay counter (clear low) while waiting, lights the go LED on its hit
// pulse, then times the player's stop press in milliseconds. The outcome is
// presented as a held result with valid, early or timeout flags until the
// next start.
//
// Ports:
//   ck        in  1        : clock, rising edge
//   reset     in  1        : asynchronous, active-high
//   start     in  1        : one-cycle pulse, begins a trial
//   stop      in  1        : one-cycle pulse, player's reaction button
//   hit       in  1        : one-cycle pulse, end of the 5 s delay
//   clear     out 1        : holds the delay counter at zero while high
//   led       out 1        : go indicator
//   result    out RESULT_W : reaction time in ms, meaningful while valid
//   valid     out 1        : result holds a completed measurement
//   early     out 1        : stop was pressed before the LED came on
//   timeout   out 1        : no stop arrived before MAX_MS
//   dbg_state out 3        : current FSM state, for observation only
//
// Handshake: start, stop and hit are single-cycle strobes sampled on the
// rising edge; there is no back-pressure. Outputs are either registered or
// decoded from the state register, so they move only on a clock edge (or
// immediately on reset).
// ---------------------------------------------------------------------------
module reflex_ctrl
    import reflex_pkg::*;
#(
    parameter int CLK_PER_MS = CLK_PER_MS_DEF,
    // Must fit in RESULT_W bits.
    parameter int MAX_MS     = MAX_MS_DEF
) (
    input  logic                ck,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                hit,
    output logic                clear,
    output logic                led,
    output logic [RESULT_W-1:0] result,
    output logic                valid,
    output logic                early,
    output logic                timeout,
    output state_e              dbg_state
);

    localparam logic [RESULT_W-1:0] MAX_CNT = RESULT_W'(MAX_MS);

    state_e              state_q;
    state_e              state_d;
    logic [RESULT_W-1:0] ms_q;
    logic [RESULT_W-1:0] ms_d;
    logic [RESULT_W-1:0] result_q;
    logic [RESULT_W-1:0] result_d;
    logic                timeout_q;
    logic                timeout_d;
    logic                tick;
    logic                tick_en;

    // The prescaler only runs while the LED is lit; it is held at 0 in every
    // other state, so GO always starts on a millisecond boundary.
    assign tick_en = (state_q == S_GO);

    ms_tick #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .ck    (ck),
        .reset (reset),
        .en    (tick_en),
        .tick  (tick)
    );

    // -----------------------------------------------------------------------
    // Next-state and datapath decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        result_d  = result_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // stop has priority over a coincident hit: the player moved
                // before the LED could have been seen.
                if (stop) begin
                    state_d = S_EARLY;
                end else if (hit) begin
                    state_d = S_GO;
                end
            end

            S_GO: begin
                if (stop) begin
                    // The current count is captured; a tick landing in the
                    // same cycle is dropped, which bounds error to 1 ms.
                    state_d  = S_DONE;
                    result_d = ms_q;
                end else if (ms_q == MAX_CNT) begin
                    state_d   = S_DONE;
                    result_d  = MAX_CNT;
                    timeout_d = 1'b1;
                end else if (tick) begin
                    ms_d = ms_q + RESULT_W'(1);
                end
            end

            S_DONE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    result_d  = '0;
                    timeout_d = 1'b0;
                end
            end

            S_EARLY: begin
                if (start) begin
                    state_d = S_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The ms counter only carries meaning inside GO; zeroing it
        // everywhere else makes GO entry start from 0 without a special case.
        if (state_d != S_GO) begin
            ms_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ms_q      <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ms_q      <= ms_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // -----------------------------------------------------------------------
    // Moore outputs. led falls on exactly the edge that enters DONE or
    // EARLY, i.e. the same edge that raises valid/early/timeout.
    // -----------------------------------------------------------------------
    assign clear     = (state_q != S_WAIT);
    assign led       = (state_q == S_GO);
    assign valid     = (state_q == S_DONE);
    assign early     = (state_q == S_EARLY);
    assign result    = result_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule : reflex_ctrl

// File: tb/tb_reflex_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reflex_ctrl
//
// Self-checking bench for reflex_ctrl with CLK_PER_MS=4, MAX_MS=20.
// Inputs change 1 time unit after a rising edge; the monitor samples on the
// falling edge. Expected trial outcomes {early, timeout, result} are queued
// when the stimulus is issued and popped by the monitor whenever valid or
// early rises.
// ---------------------------------------------------------------------------
module tb_reflex_ctrl;
    import reflex_pkg::*;

    localparam int P    = 4;
    localparam int MAXV = 20;
    localparam int W    = 2 + RESULT_W;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic ck    = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic hit   = 1'b0;

    logic                clear;
    logic                led;
    logic [RESULT_W-1:0] result;
    logic                valid;
    logic                early;
    logic                timeout;
    state_e              dbg_state;

    always #5 ck = ~ck;

    reflex_ctrl #(
        .CLK_PER_MS (P),
        .MAX_MS     (MAXV)
    ) dut (
        .ck        (ck),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .hit       (hit),
        .clear     (clear),
        .led       (led),
        .result    (result),
        .valid     (valid),
        .early     (early),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: outcome of a trial whose stop is sampled s edges after
    // the edge that sampled hit. The count reaches k at s = P*k, so a stop at
    // s sees floor((s-1)/P) ms. The count reaches MAXV at edge P*MAXV and the
    // timeout fires on the following edge unless stop arrives there first.
    // -----------------------------------------------------------------------
    function automatic logic [W-1:0] pack(input logic e, input logic t, input int r);
        return {e, t, RESULT_W'(r)};
    endfunction

    function automatic logic [W-1:0] model_stop(input int s);
        int ms;
        if (s > P * MAXV + 1) begin
            return pack(1'b0, 1'b1, MAXV);
        end
        ms = (s - 1) / P;
        if (ms > MAXV) begin
            ms = MAXV;
        end
        return pack(1'b0, 1'b0, ms);
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic pulse(input logic s_start, input logic s_stop, input logic s_hit);
        start = s_start;
        stop  = s_stop;
        hit   = s_hit;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        hit   = 1'b0;
    endtask

    // Start, wait w cycles in WAIT, hit, then stop s edges after the hit.
    // Optionally injects an ignored start pulse while the LED is lit.
    task automatic run_go_trial(input int w, input int s, input bit inject);
        int j;
        pulse(1'b1, 1'b0, 1'b0);
        check("clear_in_wait", clear, 0);
        cyc(w);
        pulse(1'b0, 1'b0, 1'b1);
        check("led_after_hit", led, 1);
        exp_q.push_back(model_stop(s));
        if (inject && s >= 3 && s <= P * MAXV + 1) begin
            j = $urandom_range(0, s - 3);
            cyc(j);
            pulse(1'b1, 1'b0, 1'b0);
            check("start_ignored_in_go", dbg_state, S_GO);
            cyc(s - 2 - j);
        end else if (s > 1) begin
            cyc(s - 1);
        end
        pulse(1'b0, 1'b1, 1'b0);
        check("state_after_stop", dbg_state, S_DONE);
        cyc(2);
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard monitor
    // -----------------------------------------------------------------------
    logic valid_prev = 1'b0;
    logic early_prev = 1'b0;

    always @(negedge ck) begin
        logic [W-1:0] e;
        if (reset) begin
            valid_prev = 1'b0;
            early_prev = 1'b0;
        end else begin
            if ((valid && !valid_prev) || (early && !early_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_outcome: got early=%0b timeout=%0b result=%0d, expected none pending",
                             early, timeout, result);
                end else begin
                    e = exp_q.pop_front();
                    check("outcome_tuple", {early, timeout, result}, e);
                    check("led_at_outcome", led, 0);
                    check("clear_at_outcome", clear, 1);
                end
            end
            valid_prev = valid;
            early_prev = early;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        int mode;
        int w;
        int s;

        reset = 1'b1;
        cyc(2);
        check("rst_clear", clear, 1);
        check("rst_led", led, 0);
        check("rst_valid", valid, 0);
        check("rst_early", early, 0);
        check("rst_timeout", timeout, 0);
        check("rst_result", result, 0);
        check("rst_state", dbg_state, S_IDLE);
        #3 reset = 1'b0;
        cyc(1);

        // stop and hit are ignored in IDLE
        pulse(1'b0, 1'b1, 1'b0);
        check("stop_ignored_idle", dbg_state, S_IDLE);
        pulse(1'b0, 1'b0, 1'b1);
        check("hit_ignored_idle", dbg_state, S_IDLE);
        check("led_idle", led, 0);

        // Normal trial: hit 10 cycles after start, stop 30 cycles after led
        pulse(1'b1, 1'b0, 1'b0);
        check("start_to_wait", dbg_state, S_WAIT);
        check("clear_falls", clear, 0);
        cyc(9);
        pulse(1'b0, 1'b0, 1'b1);
        check("led_rises", led, 1);
        exp_q.push_back(pack(1'b0, 1'b0, 7));
        cyc(10);
        pulse(1'b1, 1'b0, 1'b0);
        check("start_ignored_go", dbg_state, S_GO);
        cyc(18);
        pulse(1'b0, 1'b1, 1'b0);
        check("normal_valid", valid, 1);
        check("normal_result", result, 7);
        check("normal_led", led, 0);
        check("normal_early", early, 0);
        check("normal_timeout", timeout, 0);
        cyc(2);
        pulse(1'b0, 1'b1, 1'b1);
        check("stop_hit_ignored_done", dbg_state, S_DONE);
        check("result_held_done", result, 7);

        // Restart from DONE, then early press on the 5th WAIT edge
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_valid", valid, 0);
        check("restart_result", result, 0);
        check("restart_state", dbg_state, S_WAIT);
        cyc(4);
        check("led_off_wait", led, 0);
        exp_q.push_back(pack(1'b1, 1'b0, 0));
        pulse(1'b0, 1'b1, 1'b0);
        check("early_flag", early, 1);
        check("early_clear", clear, 1);
        check("early_led", led, 0);
        cyc(2);

        // Stop and hit in the same WAIT cycle: stop wins
        pulse(1'b1, 1'b0, 1'b0);
        check("early_cleared", early, 0);
        cyc(2);
        exp_q.push_back(pack(1'b1, 1'b0, 0));
        pulse(1'b0, 1'b1, 1'b1);
        check("sim_state", dbg_state, S_EARLY);
        check("sim_led", led, 0);
        cyc(3);
        check("sim_led_later", led, 0);

        // Timeout
        pulse(1'b1, 1'b0, 1'b0);
        cyc(1);
        pulse(1'b0, 1'b0, 1'b1);
        exp_q.push_back(pack(1'b0, 1'b1, MAXV));
        cyc(P * MAXV);
        check("still_go_at_max", dbg_state, S_GO);
        cyc(1);
        check("to_valid", valid, 1);
        check("to_timeout", timeout, 1);
        check("to_result", result, MAXV);
        check("to_led", led, 0);
        cyc(2);

        // Boundary stop times
        run_go_trial(3, 1, 1'b0);
        run_go_trial(0, 4, 1'b0);
        run_go_trial(5, 5, 1'b0);
        run_go_trial(2, P * MAXV + 1, 1'b0);
        run_go_trial(2, P * MAXV + 2, 1'b0);

        // Mid-trial asynchronous reset in GO
        pulse(1'b1, 1'b0, 1'b0);
        cyc(3);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(5);
        #3 reset = 1'b1;
        #1;
        check("ares_led", led, 0);
        check("ares_clear", clear, 1);
        check("ares_valid", valid, 0);
        check("ares_early", early, 0);
        check("ares_timeout", timeout, 0);
        check("ares_result", result, 0);
        check("ares_state", dbg_state, S_IDLE);
        cyc(1);
        #3 reset = 1'b0;
        cyc(1);
        run_go_trial(2, 10, 1'b0);

        // Randomized trials
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 3);
            w    = $urandom_range(0, 12);
            case (mode)
                0: begin
                    pulse(1'b1, 1'b0, 1'b0);
                    for (int k = 0; k < w; k++) begin
                        check("rnd_led_wait", led, 0);
                        cyc(1);
                    end
                    exp_q.push_back(pack(1'b1, 1'b0, 0));
                    pulse(1'b0, 1'b1, 1'b0);
                    cyc(2);
                    pulse(1'b0, 1'b1, 1'b1);
                    check("rnd_early_hold", dbg_state, S_EARLY);
                end
                1: begin
                    pulse(1'b1, 1'b0, 1'b0);
                    cyc(w);
                    exp_q.push_back(pack(1'b1, 1'b0, 0));
                    pulse(1'b0, 1'b1, 1'b1);
                    check("rnd_sim_led", led, 0);
                    cyc(2);
                end
                2: begin
                    s = $urandom_range(1, P * MAXV + 8);
                    run_go_trial(w, s, 1'($urandom_range(0, 1)));
                end
                default: begin
                    s = P * MAXV + $urandom_range(2, 8);
                    run_go_trial(w, s, 1'b0);
                    check("rnd_timeout_flag", timeout, 1);
                end
            endcase
        end

        // Drain the scoreboard
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            cyc(1);
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reflex_ctrl

// File: doc/reflex_ctrl.md
# reflex_ctrl

Trial controller for the reflex-measurement design, directly downstream of the 5 s delay counter. It drives that counter's `clear` and consumes its `hit` pulse to turn on the "go" LED. It then times, in milliseconds, how long the player takes to press the stop button. The result goes to the display stage together with early-press and timeout flags.

## Interface
- `CLK_PER_MS`, default 100_000: clock cycles per millisecond (100 MHz board clock).
- `MAX_MS`, default 9999: saturation limit of the reaction count, which fits a 4-digit display.
- `ck`  in  1: system clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high; forces the reset state immediately.
- `start`  in  1: one-cycle pulse (already debounced) that begins a trial.
- `stop`  in  1: one-cycle pulse (already debounced), the player's reaction button.
- `hit`  in  1: one-cycle pulse from the 5 s counter marking the end of the delay.
- `clear`  out  1: holds the 5 s counter at zero while high.
- `led`  out  1: go indicator.
- `result`  out  14: reaction time in ms; only meaningful while `valid`=1.
- `valid`  out  1: `result` holds a completed measurement.
- `early`  out  1: stop was pressed before the LED came on.
- `timeout`  out  1: no stop arrived before `MAX_MS`.

## Operation
- States: IDLE, WAIT, GO, DONE, EARLY.
- IDLE:
  - `start` → WAIT; all other inputs are ignored.
- WAIT:
  - `clear`=0, so the delay counter runs.
  - `stop` → EARLY.
  - `hit` with no `stop` → GO.
  - `stop` and `hit` in the same cycle → EARLY (stop wins).
  - `start` is ignored.
- GO:
  - `led`=1. The ms prescaler and the ms counter start from 0 on entry.
  - Each prescaler wrap increments the ms counter.
  - `stop` → DONE, with `result` set to the current ms count. A tick in the same cycle as `stop` is discarded.
  - If the ms counter reaches `MAX_MS` with no `stop` → DONE, with `result`=`MAX_MS` and `timeout`=1.
  - `start` is ignored.
- DONE:
  - `valid`=1; `result` and `timeout` are held.
  - `start` → WAIT; this clears `valid`, `timeout` and `result` (to 0).
- EARLY:
  - `early`=1.
  - `start` → WAIT and clears `early`.
- `stop` in IDLE, DONE or EARLY is ignored.
- `clear` is Moore-decoded: 0 only in WAIT, 1 in every other state.
- `hit` outside WAIT is ignored.
- Arithmetic:
  - The prescaler is ceil(log2(CLK_PER_MS)) bits, counting 0..CLK_PER_MS-1 and then wrapping.
  - The ms counter is 14 bits and never exceeds `MAX_MS`.
- Reset values: state IDLE; `clear`=1; `led`=0; `result`=0; `valid`=0; `early`=0; `timeout`=0; prescaler=0; ms counter=0.
- Asserting reset mid-trial aborts the trial with no pending flag retained.

## Timing
- All outputs are registered or decoded from state, and change only on the `ck` edge after the triggering input. The exception is `reset`, which acts asynchronously.
- `start` at edge n:
  - state becomes WAIT at n+1, and `clear` falls at n+1.
  - The delay counter's first increment is at edge n+2.
- `hit` at edge n: `led`=1 from n+1.
- The first ms tick occurs `CLK_PER_MS` cycles after GO entry.
- `stop` at edge n in GO: `valid`=1 and `result` are stable from n+1. This gives ±1 ms resolution.
- Timeout: `valid`=1 and `timeout`=1 appear one cycle after the tick that makes the count equal `MAX_MS`.
- `led` drops on the same edge that `valid`, `early` or `timeout` rises.

## Structure
- Shared package `reflex_pkg` holds:
  - the state enum (IDLE, WAIT, GO, DONE, EARLY), 3-bit encoding;
  - the default constants `CLK_PER_MS_DEF`=100_000, `MAX_MS_DEF`=9999 and `RESULT_W`=14.
- Sub-module `ms_tick`, a prescaler:
  - inputs `ck`, `reset`, `en`;
  - output `tick`, a one-cycle pulse every `CLK_PER_MS` enabled cycles;
  - returns to 0 whenever `en`=0.
  - `reflex_ctrl` drives `en` high only in GO.
- The ms counter, the FSM and the output registers live in `reflex_ctrl`.

## Test plan
Bench settings: `CLK_PER_MS`=4, `MAX_MS`=20; `hit` driven directly by the bench.
- **Normal trial:**
  - Stimulus: `start`, then `hit` 10 cycles later, then `stop` 30 cycles after `led` rises.
  - Required: `valid`=1, `result`=7, `led`=0, `early`=0, `timeout`=0.
- **Early press:** `start`, then `stop` after 5 cycles in WAIT → `early`=1, `led` never 1, `clear`=1.
- **Stop and hit in the same cycle:** pulse both in WAIT → EARLY, `early`=1, `led` stays 0.
- **Timeout:** no `stop` after `led` rises → after 80 cycles, `result`=20, `timeout`=1, `valid`=1.
- **Mid-trial reset:**
  - Assert `reset` asynchronously (between clock edges) while in GO.
  - Required: `led`=0, `clear`=1 and all flags 0 before the next edge.
  - A following `start` begins a clean trial.
- **Restart and ignored inputs:**
  - `start` while in DONE → `valid`=0 and `result`=0 next cycle, state WAIT.
  - `start` in GO and `stop` in IDLE → no state change.
